// File: rtl/endpoint_tx_driver.sv
`default_nettype none
// ============================================================================
// Module   : endpoint_tx_driver
// Brief    : Bus master that starts an endpoint TX message, streams its payload
//            words and polls for completion. Optional poll timeout enabled by
//            defining ENDPOINT_TX_DRIVER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module endpoint_tx_driver #(
    parameter int unsigned NUM_MSGS       = 4,
    parameter logic [31:0] TX_WRITE_ADDR  = 32'h0000,
    parameter logic [31:0] TX_SEND_ADDR   = 32'h0004,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_msg_id,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_word,
    input  logic        data_last,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic [31:0] bus_rdata,
    input  logic        bus_error,
    input  logic        bus_request_stall,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_START    = 3'd1;
    localparam logic [2:0] c_ST_POLL_ON  = 3'd2;
    localparam logic [2:0] c_ST_DATA     = 3'd3;
    localparam logic [2:0] c_ST_POLL_OFF = 3'd4;
    localparam logic [2:0] c_ST_FLUSH    = 3'd5;

    localparam logic [1:0] c_ERR_NONE = 2'b00;
    localparam logic [1:0] c_ERR_ID   = 2'b01;
    localparam logic [1:0] c_ERR_BUS  = 2'b10;
    localparam logic [1:0] c_ERR_TMO  = 2'b11;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_msg_id;
    logic [31:0] r_hold_data;
    logic        r_hold_last;
    logic        r_hold_valid;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [1:0]  w_code_nxt;

    logic        w_wen;
    logic        w_ren;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_xfer_ok;
    logic        w_xfer_err;
    logic        w_data_accept;
    logic        w_data_ready;
    logic        w_take;
    logic        w_bad_id;
    logic        w_timeout;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^bus_rdata[31:1];

    // Bus drive is decoded purely from registered state, never from inputs
    always_comb begin
        w_wen   = 1'b0;
        w_ren   = 1'b0;
        w_addr  = 32'h0;
        w_wdata = 32'h0;
        case (r_state)
            c_ST_START: begin
                w_wen   = 1'b1;
                w_addr  = TX_SEND_ADDR;
                w_wdata = r_msg_id;
            end
            c_ST_POLL_ON, c_ST_POLL_OFF: begin
                w_ren  = 1'b1;
                w_addr = TX_SEND_ADDR;
            end
            c_ST_DATA: begin
                if (r_hold_valid) begin
                    w_wen   = 1'b1;
                    w_addr  = TX_WRITE_ADDR;
                    w_wdata = r_hold_data;
                end
            end
            default: ;
        endcase
    end

    assign w_xfer_ok     = (w_wen || w_ren) && !bus_request_stall && !bus_error;
    assign w_xfer_err    = (w_wen || w_ren) && bus_error;
    assign w_data_accept = (r_state == c_ST_DATA) && r_hold_valid && w_xfer_ok;
    assign w_bad_id      = (cmd_msg_id >= 32'(NUM_MSGS));

    // Stop taking words once the last one is held so the next message is untouched
    assign w_data_ready = ((r_state == c_ST_DATA) &&
                           (!r_hold_valid || (w_data_accept && !r_hold_last))) ||
                          (r_state == c_ST_FLUSH);
    assign w_take       = data_valid && w_data_ready;

`ifdef ENDPOINT_TX_DRIVER_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_tmo_cnt;
    logic        w_polling;

    assign w_polling = (r_state == c_ST_POLL_ON) || (r_state == c_ST_POLL_OFF);
    assign w_timeout = w_polling && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo_cnt <= 32'h0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= 32'h0;
        end else if (w_polling) begin
            r_tmo_cnt <= r_tmo_cnt + 32'h1;
        end
    end
`else
    localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = r_err_code;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_bad_id) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = c_ERR_ID;
                    end else begin
                        w_code_nxt  = c_ERR_NONE;
                        w_state_nxt = c_ST_START;
                    end
                end
            end
            c_ST_START: begin
                if (w_xfer_err) begin
                    w_code_nxt  = c_ERR_BUS;
                    w_state_nxt = c_ST_FLUSH;
                end else if (w_xfer_ok) begin
                    w_state_nxt = c_ST_POLL_ON;
                end
            end
            c_ST_POLL_ON: begin
                if (w_xfer_err) begin
                    w_code_nxt  = c_ERR_BUS;
                    w_state_nxt = c_ST_FLUSH;
                end else if (w_xfer_ok && bus_rdata[0]) begin
                    w_state_nxt = c_ST_DATA;
                end else if (w_timeout) begin
                    w_code_nxt  = c_ERR_TMO;
                    w_state_nxt = c_ST_FLUSH;
                end
            end
            c_ST_DATA: begin
                if (w_xfer_err) begin
                    w_code_nxt = c_ERR_BUS;
                    // A held last word means upstream has nothing left to drain
                    if (r_hold_last) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_FLUSH;
                    end
                end else if (w_data_accept && r_hold_last) begin
                    w_state_nxt = c_ST_POLL_OFF;
                end
            end
            c_ST_POLL_OFF: begin
                if (w_xfer_err) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = c_ERR_BUS;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_xfer_ok && !bus_rdata[0]) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = c_ERR_TMO;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_FLUSH: begin
                if (w_take && data_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= c_ST_IDLE;
            r_msg_id   <= 32'h0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_code_nxt;
            if ((r_state == c_ST_IDLE) && cmd_valid && !w_bad_id) begin
                r_msg_id <= cmd_msg_id;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hold_data  <= 32'h0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
        end else if (r_state != c_ST_DATA) begin
            r_hold_valid <= 1'b0;
        end else if (w_xfer_err) begin
            r_hold_valid <= 1'b0;
        end else if (w_take) begin
            r_hold_data  <= data_word;
            r_hold_last  <= data_last;
            r_hold_valid <= 1'b1;
        end else if (w_data_accept) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign data_ready = w_data_ready;
    assign bus_addr   = w_addr;
    assign bus_wen    = w_wen;
    assign bus_ren    = w_ren;
    assign bus_wdata  = w_wdata;
    assign bus_strobe = w_wen ? 4'hF : 4'h0;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire
